// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the radix-4 FFT core.
//   NFFT        : points per block (4)
//   LOG2_NFFT   : log2(NFFT), also the bit growth of a full 4-point sum
//   DEF_DATA_W  : default I/Q component width
//   SCALE_SH    : output right-shift; LOG2_NFFT when FFT4_SCALE_EN is
//                 defined, 0 otherwise
//   cplx_t      : complex sample at the default width
// Configuration macro: FFT4_SCALE_EN
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int NFFT       = 4;
    localparam int LOG2_NFFT  = 2;
    localparam int DEF_DATA_W = 16;

`ifdef FFT4_SCALE_EN
    localparam int SCALE_SH = LOG2_NFFT;
`else
    localparam int SCALE_SH = 0;
`endif

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] i;
        logic signed [DEF_DATA_W-1:0] q;
    } cplx_t;

endpackage

// File: rtl/fft_bfly2.sv
// -----------------------------------------------------------------------------
// fft_bfly2
// Combinational complex add/sub pair: sum = a + b, dif = a - b.
// Outputs are one bit wider than the inputs, so no overflow is possible.
//   a_i, a_q, b_i, b_q       : signed [W-1:0] complex operands
//   sum_i, sum_q, dif_i, dif_q : signed [W:0] results
// -----------------------------------------------------------------------------
module fft_bfly2 #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] a_q,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W-1:0] b_q,
    output logic signed [W:0]   sum_i,
    output logic signed [W:0]   sum_q,
    output logic signed [W:0]   dif_i,
    output logic signed [W:0]   dif_q
);

    logic signed [W:0] ax_i, ax_q, bx_i, bx_q;

    assign ax_i = {a_i[W-1], a_i};
    assign ax_q = {a_q[W-1], a_q};
    assign bx_i = {b_i[W-1], b_i};
    assign bx_q = {b_q[W-1], b_q};

    assign sum_i = ax_i + bx_i;
    assign sum_q = ax_q + bx_q;
    assign dif_i = ax_i - bx_i;
    assign dif_q = ax_q - bx_q;

endmodule

// File: rtl/fft_radix4_core.sv
// -----------------------------------------------------------------------------
// fft_radix4_core
// Pipelined 4-point radix-4 FFT/IFFT, one block per cycle, two register stages
// with valid/ready handshakes on both sides.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready = !stall, forced 1 in reset)
//   in_i, in_q        : x0..x3, signed [DATA_W-1:0] each
//   in_inv            : 1 = inverse transform (swaps X1/X3), sampled with data
//   out_valid/out_ready : output handshake
//   out_i, out_q      : X0..X3, signed [OUT_W-1:0] each
//   blk_cnt           : blocks accepted since reset, wraps mod 2^CNT_W
// Configuration macro: FFT4_SCALE_EN (outputs shifted right by 2, OUT_W=DATA_W;
// otherwise OUT_W=DATA_W+2 unshifted).
// -----------------------------------------------------------------------------
module fft_radix4_core
    import fft_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int CNT_W  = 16,
    localparam int OUT_W  = DATA_W + LOG2_NFFT - SCALE_SH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_i [NFFT],
    input  logic signed [DATA_W-1:0] in_q [NFFT],
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_i [NFFT],
    output logic signed [OUT_W-1:0]  out_q [NFFT],
    output logic [CNT_W-1:0]         blk_cnt
);

    localparam int BW = DATA_W + 1;          // after first butterfly
    localparam int FW = DATA_W + LOG2_NFFT;  // full-precision result

    // Arithmetic shift floors toward -inf; SCALE_SH is 0 in the unscaled build.
    function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [FW-1:0] v);
        return OUT_W'(v >>> SCALE_SH);
    endfunction

    logic stall, take;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = rst | ~stall;
    assign take     = in_valid & in_ready & ~rst;

    // ---- stage 1: radix-2 butterflies x0+/-x2, x1+/-x3 ----
    logic signed [BW-1:0] e_s_i, e_s_q, e_d_i, e_d_q;
    logic signed [BW-1:0] o_s_i, o_s_q, o_d_i, o_d_q;

    fft_bfly2 #(.W(DATA_W)) u_bf_even (
        .a_i(in_i[0]), .a_q(in_q[0]), .b_i(in_i[2]), .b_q(in_q[2]),
        .sum_i(e_s_i), .sum_q(e_s_q), .dif_i(e_d_i), .dif_q(e_d_q)
    );
    fft_bfly2 #(.W(DATA_W)) u_bf_odd (
        .a_i(in_i[1]), .a_q(in_q[1]), .b_i(in_i[3]), .b_q(in_q[3]),
        .sum_i(o_s_i), .sum_q(o_s_q), .dif_i(o_d_i), .dif_q(o_d_q)
    );

    logic signed [BW-1:0] a0_i_p1, a0_q_p1, a1_i_p1, a1_q_p1;
    logic signed [BW-1:0] b0_i_p1, b0_q_p1, b1_i_p1, b1_q_p1;
    logic                 inv_p1, vld_p1;

    always_ff @(posedge clk) begin
        if (take) begin
            a0_i_p1 <= e_s_i;
            a0_q_p1 <= e_s_q;
            a1_i_p1 <= e_d_i;
            a1_q_p1 <= e_d_q;
            b0_i_p1 <= o_s_i;
            b0_q_p1 <= o_s_q;
            b1_i_p1 <= o_d_i;
            b1_q_p1 <= o_d_q;
            inv_p1  <= in_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= take;
        end
    end

    // ---- stage 2: combine, optional scaling, output registers ----
    // X1 = (x0-x2) - j(x1-x3) and X3 = (x0-x2) + j(x1-x3); -j(i,q) = (q,-i).
    logic signed [BW-1:0] c_i, c_q;
    logic signed [FW-1:0] x0_i, x0_q, x1_i, x1_q, x2_i, x2_q, x3_i, x3_q;
    logic signed [FW-1:0] xr_i [NFFT];
    logic signed [FW-1:0] xr_q [NFFT];

    assign c_i = b1_q_p1;
    assign c_q = -b1_i_p1;

    fft_bfly2 #(.W(BW)) u_bf_x02 (
        .a_i(a0_i_p1), .a_q(a0_q_p1), .b_i(b0_i_p1), .b_q(b0_q_p1),
        .sum_i(x0_i), .sum_q(x0_q), .dif_i(x2_i), .dif_q(x2_q)
    );
    fft_bfly2 #(.W(BW)) u_bf_x13 (
        .a_i(a1_i_p1), .a_q(a1_q_p1), .b_i(c_i), .b_q(c_q),
        .sum_i(x1_i), .sum_q(x1_q), .dif_i(x3_i), .dif_q(x3_q)
    );

    always_comb begin
        xr_i[0] = x0_i;
        xr_q[0] = x0_q;
        xr_i[2] = x2_i;
        xr_q[2] = x2_q;
        xr_i[1] = inv_p1 ? x3_i : x1_i;
        xr_q[1] = inv_p1 ? x3_q : x1_q;
        xr_i[3] = inv_p1 ? x1_i : x3_i;
        xr_q[3] = inv_p1 ? x1_q : x3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int k = 0; k < NFFT; k++) begin
                out_i[k] <= '0;
                out_q[k] <= '0;
            end
        end else if (!stall) begin
            out_valid <= vld_p1;
            // Bubbles leave the last delivered data in place.
            if (vld_p1) begin
                for (int k = 0; k < NFFT; k++) begin
                    out_i[k] <= scale_out(xr_i[k]);
                    out_q[k] <= scale_out(xr_q[k]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (take) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fft_radix4_core.sv
// -----------------------------------------------------------------------------
// tb_fft_radix4_core
// Self-checking bench for fft_radix4_core (DATA_W=16, CNT_W=4). Directed
// vectors come from a table; random vectors get expectations from a direct
// evaluation of the 4-point DFT. Expected blocks are queued on acceptance and
// compared when the DUT delivers them. Honours FFT4_SCALE_EN.
// -----------------------------------------------------------------------------
module tb_fft_radix4_core;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int OW = DW + LOG2_NFFT - SCALE_SH;

    typedef struct packed {
        logic [3:0][15:0] xi;
        logic [3:0][15:0] xq;
        logic             inv;
        logic [3:0][31:0] ei;
        logic [3:0][31:0] eq;
    } vec_t;

    typedef struct packed {
        logic [3:0][31:0] ei;
        logic [3:0][31:0] eq;
    } exp_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_inv, out_valid, out_ready;
    logic signed [DW-1:0] in_i [4];
    logic signed [DW-1:0] in_q [4];
    logic signed [OW-1:0] out_i [4];
    logic signed [OW-1:0] out_q [4];
    logic [CW-1:0] blk_cnt;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_out   = 0;
    exp_t cur_exp;
    exp_t mon_e;
    exp_t sbq [$];
    vec_t tbl [8];

    fft_radix4_core #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .in_q(in_q), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q),
        .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int xi [4];
        int xq [4];
        int yi [4];
        int yq [4];
        int f1i, f1q, f3i, f3q;
        for (int k = 0; k < 4; k++) begin
            xi[k] = int'($signed(v.xi[k]));
            xq[k] = int'($signed(v.xq[k]));
        end
        yi[0] = xi[0] + xi[1] + xi[2] + xi[3];
        yq[0] = xq[0] + xq[1] + xq[2] + xq[3];
        yi[2] = xi[0] - xi[1] + xi[2] - xi[3];
        yq[2] = xq[0] - xq[1] + xq[2] - xq[3];
        f1i = xi[0] + xq[1] - xi[2] - xq[3];
        f1q = xq[0] - xi[1] - xq[2] + xi[3];
        f3i = xi[0] - xq[1] - xi[2] + xq[3];
        f3q = xq[0] + xi[1] - xq[2] - xi[3];
        yi[1] = v.inv ? f3i : f1i;
        yq[1] = v.inv ? f3q : f1q;
        yi[3] = v.inv ? f1i : f3i;
        yq[3] = v.inv ? f1q : f3q;
        for (int k = 0; k < 4; k++) begin
            r.ei[k] = yi[k];
            r.eq[k] = yq[k];
        end
        return r;
    endfunction

    function automatic vec_t rand_vec(input logic inv);
        vec_t v = '0;
        for (int k = 0; k < 4; k++) begin
            v.xi[k] = 16'($urandom);
            v.xq[k] = 16'($urandom);
        end
        v.inv = inv;
        return model(v);
    endfunction

    task automatic set_vec(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            in_i[k] = v.xi[k];
            in_q[k] = v.xq[k];
            cur_exp.ei[k] = 32'($signed(v.ei[k]) >>> SCALE_SH);
            cur_exp.eq[k] = 32'($signed(v.eq[k]) >>> SCALE_SH);
        end
        in_inv = v.inv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain queue empty", sbq.size(), 0);
        step();
    endtask

    // Single block into an empty pipe: valid must rise two cycles after the
    // accepting cycle and not earlier.
    task automatic lat_seq(input string tag);
        in_valid = 1'b1;
        @(negedge clk);
        chk({tag, " in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, " out_valid cycle1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, " out_valid cycle2"}, out_valid, 1);
        step();
    endtask

    task automatic set_e(input int t, input int k, input int ei, input int eq);
        tbl[t].ei[k] = ei;
        tbl[t].eq[k] = eq;
    endtask

    // Scoreboard: compare on the cycle an output transfer is presented, then
    // queue the block being accepted in the same cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_total++;
                    $display("FAIL stale output: got unexpected block X0=(%0d,%0d), expected none",
                             out_i[0], out_q[0]);
                end else begin
                    mon_e = sbq.pop_front();
                    n_out++;
                    for (int k = 0; k < 4; k++) begin
                        chk($sformatf("blk%0d X%0d i", n_out, k), out_i[k], $signed(mon_e.ei[k]));
                        chk($sformatf("blk%0d X%0d q", n_out, k), out_q[k], $signed(mon_e.eq[k]));
                    end
                end
            end
            if (in_valid && in_ready) sbq.push_back(cur_exp);
        end
    end

    initial begin
        logic signed [OW-1:0] snap_i, snap_q;
        int n0;

        rst = 1'b1;
        in_valid = 1'b0;
        in_inv = 1'b0;
        out_ready = 1'b1;
        cur_exp = '0;
        for (int k = 0; k < 4; k++) begin
            in_i[k] = '0;
            in_q[k] = '0;
        end

        for (int t = 0; t < 8; t++) tbl[t] = '0;
        // impulse at x0
        tbl[0].xi[0] = 16'd100;
        for (int k = 0; k < 4; k++) set_e(0, k, 100, 0);
        // impulse at x1, forward and inverse
        tbl[1].xi[1] = 16'd100;
        set_e(1, 0, 100, 0); set_e(1, 1, 0, -100); set_e(1, 2, -100, 0); set_e(1, 3, 0, 100);
        tbl[2].xi[1] = 16'd100;
        tbl[2].inv = 1'b1;
        set_e(2, 0, 100, 0); set_e(2, 1, 0, 100); set_e(2, 2, -100, 0); set_e(2, 3, 0, -100);
        // most negative inputs, forward and inverse
        for (int k = 0; k < 4; k++) begin
            tbl[3].xi[k] = 16'h8000; tbl[3].xq[k] = 16'h8000;
            tbl[4].xi[k] = 16'h8000; tbl[4].xq[k] = 16'h8000;
        end
        tbl[4].inv = 1'b1;
        set_e(3, 0, -131072, -131072);
        set_e(4, 0, -131072, -131072);
        tbl[5] = rand_vec(1'b0);
        tbl[6] = rand_vec(1'b1);
        tbl[7] = rand_vec(1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset blk_cnt", blk_cnt, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_i[0]", out_i[0], 0);
        chk("reset out_q[3]", out_q[3], 0);
        step();
        rst = 1'b0;

        // Latency on the impulse
        set_vec(tbl[0]);
        lat_seq("latency");
        drain();

        // Table, back to back
        for (int t = 0; t < 8; t++) begin
            set_vec(tbl[t]);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("table blk_cnt", blk_cnt, 9);

        // Backpressure: three blocks offered while the sink is stalled
        do_reset();
        n0 = n_out;
        out_ready = 1'b0;
        set_vec(rand_vec(1'b0));
        in_valid = 1'b1;
        step();
        set_vec(rand_vec(1'b1));
        step();
        set_vec(rand_vec(1'b0));
        @(negedge clk);
        chk("bp in_ready low", in_ready, 0);
        chk("bp out_valid", out_valid, 1);
        snap_i = out_i[0];
        snap_q = out_q[2];
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("bp hold out_valid", out_valid, 1);
            chk("bp hold out_i[0]", out_i[0], snap_i);
            chk("bp hold out_q[2]", out_q[2], snap_q);
            chk("bp hold in_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drain();
        chk("bp blk_cnt", blk_cnt, 3);
        chk("bp delivered", n_out - n0, 3);

        // Reset with two blocks in flight and the sink stalled
        do_reset();
        out_ready = 1'b1;
        set_vec(rand_vec(1'b0));
        in_valid = 1'b1;
        step();
        set_vec(rand_vec(1'b1));
        step();
        n0 = n_out;
        rst = 1'b1;
        out_ready = 1'b0;
        set_vec(rand_vec(1'b0));
        @(negedge clk);
        chk("rst mid in_ready", in_ready, 1);
        chk("rst mid block in flight", out_valid, 1);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst mid out_valid", out_valid, 0);
        chk("rst mid blk_cnt", blk_cnt, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("rst mid no stale", out_valid, 0);
        end
        step();
        chk("rst mid nothing delivered", n_out - n0, 0);
        set_vec(rand_vec(1'b1));
        lat_seq("post-reset latency");
        drain();
        chk("post-reset blk_cnt", blk_cnt, 1);

        // Counter wrap
        do_reset();
        for (int t = 0; t < 17; t++) begin
            set_vec(rand_vec(1'(t % 2)));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("wrap blk_cnt", blk_cnt, 1);

        chk("final queue empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
